// File: rtl/imm_encoder_if.sv
// ---------------------------------------------------------------------------
// imm_encoder_if
// Request/result bundle for the immediate encoder.
//   master : drives Start, Value, ImmSrc; observes the result fields
//   slave  : the encoder itself
// Signals:
//   Start    request pulse (sampled only while the encoder is idle)
//   Value    32-bit constant or byte offset to encode
//   ImmSrc   00 data-processing, 01 LDR/STR, 10 branch, 11 reserved
//   Busy     high while the search is running
//   Done     one-cycle completion pulse
//   Valid    result is encodable
//   Imm      24-bit instruction immediate field
//   Up       LDR/STR U bit
//   Inverted result encodes ~Value (MVN/BIC form)
// ---------------------------------------------------------------------------
interface imm_encoder_if;
  logic        Start;
  logic [31:0] Value;
  logic [1:0]  ImmSrc;
  logic        Busy;
  logic        Done;
  logic        Valid;
  logic [23:0] Imm;
  logic        Up;
  logic        Inverted;

  modport master (
    output Start, Value, ImmSrc,
    input  Busy, Done, Valid, Imm, Up, Inverted
  );

  modport slave (
    input  Start, Value, ImmSrc,
    output Busy, Done, Valid, Imm, Up, Inverted
  );
endinterface

// File: rtl/imm_encoder.sv
// ---------------------------------------------------------------------------
// imm_encoder
// Encodes a 32-bit constant or offset into an ARM-style instruction
// immediate field. Data-processing immediates are found by a sequential
// search over the 16 even rotations (one rotation per cycle, lowest wins);
// LDR/STR offsets and branch offsets resolve in a single search cycle.
//
// Ports:
//   CLK      rising-edge clock
//   Reset_n  asynchronous active-low reset (aborts any search in progress)
//   bus      imm_encoder_if.slave request/result bundle
//
// Build option:
//   IMM_ENC_INVERT_EN  when defined, a failed data-processing search is
//                      followed by a second 16-rotation pass over ~Value
//                      and a hit there reports Inverted=1. When undefined
//                      there is no second pass and Inverted is tied to 0.
// ---------------------------------------------------------------------------
module imm_encoder (
  input  logic          CLK,
  input  logic          Reset_n,
  imm_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_value;
  logic [1:0]  r_src;
  logic [3:0]  r_rot;
  logic        r_busy;
  logic        r_done;
  logic        r_valid;
  logic [23:0] r_imm;
  logic        r_up;
`ifdef IMM_ENC_INVERT_EN
  logic        r_pass;     // 0: direct pass over Value, 1: pass over ~Value
  logic        r_inv;
`endif

  logic [31:0] w_src_val;
  logic [4:0]  w_shamt;
  logic [5:0]  w_rshamt;
  logic [31:0] w_rol;
  logic        w_rot_hit;
  logic [31:0] w_neg;
  logic        w_ldr_pos;
  logic        w_ldr_neg;
  logic        w_br_ok;
  logic        w_fin;
  logic        w_valid;
  logic [23:0] w_imm;
  logic        w_up;
`ifdef IMM_ENC_INVERT_EN
  logic        w_inv;
`endif

  // Operand of the current rotation test and its left-rotation by 2r.
  // Value == ROR(imm8, 2r) exactly when ROL(Value, 2r) fits in 8 bits.
  always_comb begin
`ifdef IMM_ENC_INVERT_EN
    w_src_val = r_pass ? ~r_value : r_value;
`else
    w_src_val = r_value;
`endif
    w_shamt   = {r_rot, 1'b0};
    w_rshamt  = 6'd32 - {1'b0, w_shamt};
    // A right shift by 32 (r=0) yields 0, so the OR reduces to Value.
    w_rol     = (w_src_val << w_shamt) | (w_src_val >> w_rshamt);
    w_rot_hit = (w_rol[31:8] == 24'd0);
  end

  // LDR/STR and branch range checks on the captured value.
  always_comb begin
    w_neg     = 32'd0 - r_value;
    w_ldr_pos = (r_value[31:12] == 20'd0);
    // -4095..-1: negative with magnitude below 4096.
    w_ldr_neg = r_value[31] && (w_neg[31:12] == 20'd0);
    w_br_ok   = (r_value[1:0] == 2'b00) &&
                ((r_value[31:25] == 7'h00) || (r_value[31:25] == 7'h7F));
  end

  // Result of the current SEARCH cycle and whether it ends the search.
  always_comb begin
    w_fin   = 1'b0;
    w_valid = 1'b0;
    w_imm   = 24'd0;
    w_up    = 1'b0;
`ifdef IMM_ENC_INVERT_EN
    w_inv   = 1'b0;
`endif
    case (r_src)
      2'b00: begin
        if (w_rot_hit) begin
          w_fin   = 1'b1;
          w_valid = 1'b1;
          w_imm   = {12'd0, r_rot, w_rol[7:0]};
`ifdef IMM_ENC_INVERT_EN
          w_inv   = r_pass;
`endif
        end else if (r_rot == 4'd15) begin
`ifdef IMM_ENC_INVERT_EN
          w_fin = r_pass;
`else
          w_fin = 1'b1;
`endif
        end else begin
          w_fin = 1'b0;
        end
      end
      2'b01: begin
        w_fin = 1'b1;
        if (w_ldr_pos) begin
          w_valid = 1'b1;
          w_up    = 1'b1;
          w_imm   = {12'd0, r_value[11:0]};
        end else if (w_ldr_neg) begin
          w_valid = 1'b1;
          w_up    = 1'b0;
          w_imm   = {12'd0, w_neg[11:0]};
        end else begin
          w_valid = 1'b0;
        end
      end
      2'b10: begin
        w_fin = 1'b1;
        if (w_br_ok) begin
          w_valid = 1'b1;
          w_imm   = r_value[25:2];
        end else begin
          w_valid = 1'b0;
        end
      end
      default: begin
        w_fin = 1'b1;
      end
    endcase
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_value <= 32'd0;
      r_src   <= 2'b00;
      r_rot   <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_imm   <= 24'd0;
      r_up    <= 1'b0;
`ifdef IMM_ENC_INVERT_EN
      r_pass  <= 1'b0;
      r_inv   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.Start) begin
            r_state <= ST_SEARCH;
            r_value <= bus.Value;
            r_src   <= bus.ImmSrc;
            r_rot   <= 4'd0;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
            r_imm   <= 24'd0;
            r_up    <= 1'b0;
`ifdef IMM_ENC_INVERT_EN
            r_pass  <= 1'b0;
            r_inv   <= 1'b0;
`endif
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SEARCH: begin
          if (w_fin) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_valid <= w_valid;
            r_imm   <= w_imm;
            r_up    <= w_up;
`ifdef IMM_ENC_INVERT_EN
            r_inv   <= w_inv;
`endif
          end else begin
`ifdef IMM_ENC_INVERT_EN
            // Direct pass exhausted: restart the rotations over ~Value.
            if (r_rot == 4'd15) begin
              r_pass <= 1'b1;
              r_rot  <= 4'd0;
            end else begin
              r_rot  <= r_rot + 4'd1;
            end
`else
            r_rot <= r_rot + 4'd1;
`endif
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy  = r_busy;
  assign bus.Done  = r_done;
  assign bus.Valid = r_valid;
  assign bus.Imm   = r_imm;
  assign bus.Up    = r_up;
`ifdef IMM_ENC_INVERT_EN
  assign bus.Inverted = r_inv;
`else
  assign bus.Inverted = 1'b0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// ---------------------------------------------------------------------------
// tb_imm_encoder
// Directed, table-driven bench for imm_encoder. Each table row holds the
// request and the hand-computed completion cycle and result fields. A few
// hand-written sequences cover ignored re-starts and reset mid-search.
// Works with and without IMM_ENC_INVERT_EN defined.
// ---------------------------------------------------------------------------
module tb_imm_encoder;

  logic CLK;
  logic Reset_n;
  imm_encoder_if bus ();

  imm_encoder dut (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

`ifdef IMM_ENC_INVERT_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0]  src;
    logic [31:0] val;
    int          cyc;
    logic        valid;
    logic [23:0] imm;
    logic        up;
    logic        inv;
    bit          chk_imm;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] src, input logic [31:0] val, input int cyc,
                     input logic valid, input logic [23:0] imm, input logic up,
                     input logic inv, input bit chk_imm);
    vec_t v;
    v.src = src; v.val = val; v.cyc = cyc; v.valid = valid;
    v.imm = imm; v.up = up; v.inv = inv; v.chk_imm = chk_imm;
    vecs.push_back(v);
  endtask

  // Waits (bounded) for Done starting from cycle k0; returns cycle or -1.
  task automatic wait_done(input int k0, output int cyc);
    int k;
    cyc = -1;
    k = k0;
    while (cyc == -1 && k <= 40) begin
      if (bus.Done === 1'b1) cyc = k;
      else begin
        @(negedge CLK);
        k++;
      end
    end
  endtask

  // Issues a request; returns at the negedge of the Done cycle.
  task automatic run_txn(input logic [1:0] src, input logic [31:0] val, output int cyc);
    @(negedge CLK);
    bus.Start = 1'b1; bus.ImmSrc = src; bus.Value = val;
    @(negedge CLK);  // cycle 1
    bus.Start = 1'b0;
    chk("busy_c1", {31'd0, bus.Busy}, 32'd1);
    chk("clr_valid", {31'd0, bus.Valid}, 32'd0);
    chk("clr_imm", {8'd0, bus.Imm}, 32'd0);
    wait_done(1, cyc);
  endtask

  initial begin
    int cyc;
    int extra;

    bus.Start = 1'b0; bus.Value = 32'd0; bus.ImmSrc = 2'b00;
    Reset_n = 1'b0;

    // Expected values are hand-derived.
    add(2'b00, 32'h0000_00FF,  2, 1'b1, 24'h0000FF, 1'b0, 1'b0, 1'b1);
    add(2'b00, 32'hFF00_0000,  6, 1'b1, 24'h0004FF, 1'b0, 1'b0, 1'b1);
    add(2'b00, 32'h0000_0000,  2, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b1);
    add(2'b00, 32'hC000_003F,  3, 1'b1, 24'h0001FF, 1'b0, 1'b0, 1'b1);
    add(2'b00, 32'h0000_03FC, 17, 1'b1, 24'h000FFF, 1'b0, 1'b0, 1'b1);
    add(2'b00, 32'h0000_0101, INV_EN ? 33 : 17, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1);
    if (INV_EN)
      add(2'b00, 32'hFFFF_FF00, 18, 1'b1, 24'h0000FF, 1'b0, 1'b1, 1'b1);
    else
      add(2'b00, 32'hFFFF_FF00, 17, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1);
    add(2'b01, 32'hFFFF_FFFC,  2, 1'b1, 24'h000004, 1'b0, 1'b0, 1'b1);
    add(2'b01, 32'h0000_1000,  2, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0);
    add(2'b01, 32'h0000_0FFF,  2, 1'b1, 24'h000FFF, 1'b1, 1'b0, 1'b1);
    add(2'b01, 32'h0000_0000,  2, 1'b1, 24'h000000, 1'b1, 1'b0, 1'b1);
    add(2'b01, 32'hFFFF_F001,  2, 1'b1, 24'h000FFF, 1'b0, 1'b0, 1'b1);
    add(2'b01, 32'hFFFF_F000,  2, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0);
    add(2'b10, 32'hFFFF_FFF8,  2, 1'b1, 24'hFFFFFE, 1'b0, 1'b0, 1'b1);
    add(2'b10, 32'h01FF_FFFC,  2, 1'b1, 24'h7FFFFF, 1'b0, 1'b0, 1'b1);
    add(2'b10, 32'h0000_0006,  2, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0);
    add(2'b10, 32'h0200_0000,  2, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0);
    add(2'b11, 32'h1234_5678,  2, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1);

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_busy",  {31'd0, bus.Busy},  32'd0);
    chk("rst_done",  {31'd0, bus.Done},  32'd0);
    chk("rst_valid", {31'd0, bus.Valid}, 32'd0);
    chk("rst_imm",   {8'd0, bus.Imm},    32'd0);
    Reset_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      run_txn(vecs[i].src, vecs[i].val, cyc);
      chk($sformatf("v%0d_done_cycle", i), cyc, vecs[i].cyc);
      chk($sformatf("v%0d_valid", i), {31'd0, bus.Valid}, {31'd0, vecs[i].valid});
      chk($sformatf("v%0d_inv", i), {31'd0, bus.Inverted}, {31'd0, vecs[i].inv});
      if (vecs[i].chk_imm) begin
        chk($sformatf("v%0d_imm", i), {8'd0, bus.Imm}, {8'd0, vecs[i].imm});
        chk($sformatf("v%0d_up", i), {31'd0, bus.Up}, {31'd0, vecs[i].up});
      end
      @(negedge CLK);  // back in IDLE: pulse over, result held
      chk($sformatf("v%0d_done_pulse", i), {31'd0, bus.Done}, 32'd0);
      chk($sformatf("v%0d_hold_valid", i), {31'd0, bus.Valid}, {31'd0, vecs[i].valid});
    end

    // Start during SEARCH is ignored, not queued
    @(negedge CLK);
    bus.Start = 1'b1; bus.ImmSrc = 2'b00; bus.Value = 32'hFF00_0000;
    @(negedge CLK);  // cycle 1
    bus.Start = 1'b0;
    @(negedge CLK);  // cycle 2
    @(negedge CLK);  // cycle 3
    bus.Start = 1'b1; bus.Value = 32'h0000_00FF;
    @(negedge CLK);  // cycle 4
    bus.Start = 1'b0;
    wait_done(4, cyc);
    chk("ign_done_cycle", cyc, 32'd6);
    chk("ign_imm", {8'd0, bus.Imm}, 32'h0004FF);
    extra = 0;
    repeat (20) begin
      @(negedge CLK);
      if (bus.Done === 1'b1 || bus.Busy === 1'b1) extra++;
    end
    chk("ign_no_queue", extra, 32'd0);

    // Reset mid-search aborts; no Done follows
    @(negedge CLK);
    bus.Start = 1'b1; bus.ImmSrc = 2'b00; bus.Value = 32'h0000_0101;
    @(negedge CLK);  // cycle 1
    bus.Start = 1'b0;
    @(negedge CLK);  // cycle 2
    @(negedge CLK);  // cycle 3
    bus.Start = 1'b1;
    @(negedge CLK);  // cycle 4
    bus.Start = 1'b0;
    chk("abort_busy_c4", {31'd0, bus.Busy}, 32'd1);
    @(negedge CLK);  // cycle 5
    Reset_n = 1'b0;
    #1;
    chk("abort_busy",  {31'd0, bus.Busy},     32'd0);
    chk("abort_done",  {31'd0, bus.Done},     32'd0);
    chk("abort_valid", {31'd0, bus.Valid},    32'd0);
    chk("abort_imm",   {8'd0, bus.Imm},       32'd0);
    chk("abort_up",    {31'd0, bus.Up},       32'd0);
    chk("abort_inv",   {31'd0, bus.Inverted}, 32'd0);
    @(negedge CLK);
    Reset_n = 1'b1;
    extra = 0;
    repeat (40) begin
      @(negedge CLK);
      if (bus.Done === 1'b1) extra++;
    end
    chk("abort_no_done", extra, 32'd0);
    run_txn(2'b00, 32'h0000_00FF, cyc);
    chk("post_done_cycle", cyc, 32'd2);
    chk("post_valid", {31'd0, bus.Valid}, 32'd1);
    chk("post_imm", {8'd0, bus.Imm}, 32'h0000FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
